age_quant_pipe: RTL

AGE_QUANT_PIPE -- requirements
Module: age_quant_pipe

---
 rtl/age_quant_pkg.sv | 24 ++
 rtl/age_quant_ch.sv | 78 +++++++
 rtl/age_quant_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/age_quant_pkg.sv
// age_quant_pkg: shared widths and the stage-2 saturating age quantiser
// used by age_quant_pipe and age_quant_ch.
package age_quant_pkg;

  localparam int unsigned TS_BITS_DEF   = 16;
  localparam int unsigned POL_BITS_DEF  = 2;
  localparam int unsigned WORD_BITS_DEF = 18;
  localparam int unsigned NUM_CH_DEF    = 2;
  localparam int unsigned ACT_BITS_DEF  = 8;
  localparam int unsigned SHIFT_BITS    = 4;
  localparam int unsigned CNT_BITS      = 16;

  // act = max - min(age >> shift, max); a result of 0 means the channel saturated
  function automatic logic [31:0] quant_act(input logic [31:0]           age,
                                            input logic [SHIFT_BITS-1:0] shift,
                                            input int unsigned           act_bits);
    logic [31:0] max_act;
    logic [31:0] q;
    max_act = (32'd1 << act_bits) - 32'd1;
    q       = age >> shift;
    return (q >= max_act) ? 32'd0 : (max_act - q);
  endfunction

endpackage

// File: rtl/age_quant_ch.sv
// age_quant_ch: per-channel two-stage datapath.
//   stage 1: age = cur_ts - ts (modular), polarity and shift captured
//   stage 2: act quantised from age, polarity passed on, sat flag
// Ports: clk, rst (sync, active high), en (global pipeline enable),
//   in_word {ts, pol}, cur_ts, age_shift -> act, pol, sat (all registered).
module age_quant_ch
  import age_quant_pkg::*;
#(
  parameter int unsigned TIMESTAMP_BITS = TS_BITS_DEF,
  parameter int unsigned POLARITY_BITS  = POL_BITS_DEF,
  parameter int unsigned WORD_SIZE      = WORD_BITS_DEF,
  parameter int unsigned ACT_BITS       = ACT_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WORD_SIZE-1:0]      in_word,
  input  logic [TIMESTAMP_BITS-1:0] cur_ts,
  input  logic [SHIFT_BITS-1:0]     age_shift,
  output logic [ACT_BITS-1:0]       act,
  output logic [POLARITY_BITS-1:0]  pol,
  output logic                      sat
);

  logic [TIMESTAMP_BITS-1:0] ts;
  logic [TIMESTAMP_BITS-1:0] age_d, age_q;
  logic [POLARITY_BITS-1:0]  pol1_d, pol1_q;
  logic [SHIFT_BITS-1:0]     shift_d, shift_q;
  logic [ACT_BITS-1:0]       act_d, act_q;
  logic [POLARITY_BITS-1:0]  pol2_d, pol2_q;
  logic                      sat_d, sat_q;
  logic [31:0]               act_full;

  assign ts = in_word[POLARITY_BITS +: TIMESTAMP_BITS];

  // Next-state for both stages; everything holds when the pipe is stalled
  always_comb begin
    age_d    = age_q;
    pol1_d   = pol1_q;
    shift_d  = shift_q;
    act_d    = act_q;
    pol2_d   = pol2_q;
    sat_d    = sat_q;
    act_full = quant_act(32'(age_q), shift_q, ACT_BITS);
    if (en) begin
      age_d   = cur_ts - ts;
      pol1_d  = in_word[POLARITY_BITS-1:0];
      shift_d = age_shift;
      // Polarity 0 means no event: force act to 0 and never flag saturation
      act_d   = (pol1_q != '0) ? ACT_BITS'(act_full) : '0;
      pol2_d  = pol1_q;
      sat_d   = (pol1_q != '0) && (act_full == 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q   <= '0;
      pol1_q  <= '0;
      shift_q <= '0;
      act_q   <= '0;
      pol2_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      age_q   <= age_d;
      pol1_q  <= pol1_d;
      shift_q <= shift_d;
      act_q   <= act_d;
      pol2_q  <= pol2_d;
      sat_q   <= sat_d;
    end
  end

  assign act = act_q;
  assign pol = pol2_q;
  assign sat = sat_q;

endmodule

// File: rtl/age_quant_pipe.sv
// age_quant_pipe: two-stage pipeline converting event-word ages into
// per-channel activations, with valid/ready handshake and a saturating
// count of saturated channels.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data/cur_ts/
//   age_shift on the input side; out_valid/out_ready/out_act/out_pol on the
//   output side; sat_cnt with synchronous clear sat_clr.
module age_quant_pipe
  import age_quant_pkg::*;
#(
  parameter int unsigned TIMESTAMP_BITS = TS_BITS_DEF,
  parameter int unsigned POLARITY_BITS  = POL_BITS_DEF,
  parameter int unsigned WORD_SIZE      = WORD_BITS_DEF,
  parameter int unsigned NUM_CH         = NUM_CH_DEF,
  parameter int unsigned ACT_BITS       = ACT_BITS_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_CH*WORD_SIZE-1:0]       in_data,
  input  logic [TIMESTAMP_BITS-1:0]         cur_ts,
  input  logic [SHIFT_BITS-1:0]             age_shift,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*ACT_BITS-1:0]        out_act,
  output logic [NUM_CH*POLARITY_BITS-1:0]   out_pol,
  output logic [CNT_BITS-1:0]               sat_cnt,
  input  logic                              sat_clr
);

  localparam int unsigned SUM_BITS = CNT_BITS + 1;

  logic                v1_d, v1_q;
  logic                v2_d, v2_q;
  logic [CNT_BITS-1:0] sat_cnt_d, sat_cnt_q;
  logic [SUM_BITS-1:0] sat_sum;
  logic [NUM_CH-1:0]   sat_vec;
  logic                en;
  logic                out_xfer;

  // Whole pipe advances together whenever the output slot is free or draining
  assign en       = out_ready || !v2_q;
  assign in_ready = en;
  assign out_xfer = v2_q && out_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    age_quant_ch #(
      .TIMESTAMP_BITS (TIMESTAMP_BITS),
      .POLARITY_BITS  (POLARITY_BITS),
      .WORD_SIZE      (WORD_SIZE),
      .ACT_BITS       (ACT_BITS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_word   (in_data[k*WORD_SIZE +: WORD_SIZE]),
      .cur_ts    (cur_ts),
      .age_shift (age_shift),
      .act       (out_act[k*ACT_BITS +: ACT_BITS]),
      .pol       (out_pol[k*POLARITY_BITS +: POLARITY_BITS]),
      .sat       (sat_vec[k])
    );
  end

  // Valid flags and saturation counter; clear beats a same-cycle increment
  always_comb begin
    v1_d      = v1_q;
    v2_d      = v2_q;
    sat_cnt_d = sat_cnt_q;
    sat_sum   = {1'b0, sat_cnt_q};
    for (int k = 0; k < NUM_CH; k++) begin
      sat_sum = sat_sum + SUM_BITS'(sat_vec[k]);
    end
    if (en) begin
      v1_d = in_valid;
      v2_d = v1_q;
    end
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_xfer) begin
      sat_cnt_d = sat_sum[CNT_BITS] ? '1 : sat_sum[CNT_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign out_valid = v2_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
